// File: rtl/codec_sample_receiver_pkg.sv
// Shared constants and helpers for the codec receive path.
// Sample width is common with the codec conditioner.
package codec_sample_receiver_pkg;

  localparam int SAMPLE_WIDTH       = 16;
  localparam int DEFAULT_DEPTH_LOG2 = 3;
  localparam int DROP_CNT_W         = 8;

  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/codec_sample_receiver_fifo.sv
// Register-array FIFO with first-word fall-through; dout is valid one cycle after a push.
// A push is accepted when not full, or when full and a pop happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [WIDTH-1:0]      i_din,
  output logic [WIDTH-1:0]      o_dout,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_empty = (r_count == '0);
  // Count never exceeds DEPTH, so its MSB alone marks full.
  assign o_full  = r_count[DEPTH_LOG2];
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/codec_sample_receiver.sv
// Captures one codec ADC sample per new_frame rising edge into a FIFO, drained with valid/ready.
// Full FIFO without a same-cycle pop drops the sample and records it in overflow/drop_count.
module codec_sample_receiver
  import codec_sample_receiver_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_new_frame,
  input  logic [WIDTH-1:0]      i_sample_in,
  output logic                  o_sample_captured,
  output logic [WIDTH-1:0]      o_sample_out,
  output logic                  o_sample_valid,
  input  logic                  i_sample_ready,
  output logic [DEPTH_LOG2:0]   o_fill_level,
  output logic                  o_overflow,
  output logic [DROP_CNT_W-1:0] o_drop_count,
  input  logic                  i_clear_overflow
);

  logic                  r_new_frame_d;
  logic                  r_armed;
  logic                  r_captured;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_count;

  logic w_frame_evt;
  logic w_push;
  logic w_pop;
  logic w_accept;
  logic w_drop;
  logic w_full;
  logic w_empty;

  // r_armed masks the first cycle after reset so a strobe already high is not seen as an edge.
  assign w_frame_evt = i_new_frame & ~r_new_frame_d & r_armed;
  assign w_push      = w_frame_evt & i_enable;
  assign w_pop       = ~w_empty & i_sample_ready;
  assign w_accept    = w_push & (~w_full | w_pop) & ~i_flush;
  assign w_drop      = w_push & w_full & ~w_pop & ~i_flush;

  sample_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_flush),
    .i_din   (i_sample_in),
    .o_dout  (o_sample_out),
    .o_count (o_fill_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_new_frame_d <= 1'b0;
      r_armed       <= 1'b0;
      r_captured    <= 1'b0;
    end else begin
      r_new_frame_d <= i_new_frame;
      r_armed       <= 1'b1;
      r_captured    <= w_accept;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (i_clear_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= sat_inc(r_drop_count);
    end
  end

  assign o_sample_valid    = ~w_empty;
  assign o_sample_captured = r_captured;
  assign o_overflow        = r_overflow;
  assign o_drop_count      = r_drop_count;

endmodule

// File: tb/tb_codec_sample_receiver.sv
// Scoreboard bench: a queue-based reference model predicts each cycle; a monitor checks popped samples.
module tb_codec_sample_receiver;

  localparam int W     = 16;
  localparam int DL2   = 3;
  localparam int DEPTH = 1 << DL2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b1;
  logic           flush = 1'b0;
  logic           nf = 1'b0;
  logic [W-1:0]   sin = '0;
  logic           rdy = 1'b0;
  logic           clr = 1'b0;
  logic           cap;
  logic [W-1:0]   sout;
  logic           vld;
  logic [DL2:0]   fill;
  logic           ovf;
  logic [7:0]     dc;

  int errors = 0;
  int checks = 0;

  codec_sample_receiver #(.WIDTH(W), .DEPTH_LOG2(DL2)) dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_enable         (en),
    .i_flush          (flush),
    .i_new_frame      (nf),
    .i_sample_in      (sin),
    .o_sample_captured(cap),
    .o_sample_out     (sout),
    .o_sample_valid   (vld),
    .i_sample_ready   (rdy),
    .o_fill_level     (fill),
    .o_overflow       (ovf),
    .o_drop_count     (dc),
    .i_clear_overflow (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entry count, captured-pulse, overflow state and an expected-data queue.
  int         m_count = 0;
  bit         m_prev = 0, m_first = 1, m_cap = 0, m_ovf = 0;
  int         m_dc = 0;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    bit evt, pop, push, drop;
    drop = 0;
    if (!rst_n) begin
      chk("rst_fill", fill, 0);
      chk("rst_valid", vld, 0);
      chk("rst_out", sout, 0);
      chk("rst_cap", cap, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_dc", dc, 0);
      m_count = 0; m_prev = 0; m_first = 1; m_cap = 0; m_ovf = 0; m_dc = 0;
      exp_q.delete();
    end else begin
      chk("fill_level", fill, m_count);
      chk("sample_valid", vld, m_count > 0);
      chk("sample_captured", cap, m_cap);
      chk("overflow", ovf, m_ovf);
      chk("drop_count", dc, m_dc);
      evt = !m_first && nf && !m_prev;
      m_prev = nf;
      m_first = 0;
      pop = (m_count > 0) && rdy;
      m_cap = 0;
      if (flush) begin
        m_count = 0;
        exp_q.delete();
      end else begin
        push = evt && en;
        if (pop) m_count--;
        if (push) begin
          if (m_count + (pop ? 1 : 0) < DEPTH || pop) begin
            exp_q.push_back(sin);
            m_cap = 1;
            m_count++;
          end else begin
            drop = 1;
          end
        end
      end
      if (clr) begin
        m_ovf = 0; m_dc = 0;
      end else if (drop) begin
        m_ovf = 1;
        if (m_dc < 255) m_dc++;
      end
    end
  end

  // Monitor: every accepted pop must deliver the oldest captured sample.
  always @(posedge clk) begin
    if (rst_n && vld && rdy && !flush) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL pop_unexpected: got %0h expected none", sout);
      end else begin
        chk("pop_data", sout, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [W-1:0] v);
    nf = 1'b1; sin = v; cyc();
    nf = 1'b0; cyc();
  endtask

  task automatic do_flush();
    flush = 1'b1; cyc();
    flush = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: strobe high across reset release
    nf = 1'b1; sin = 16'hBEEF;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("t1_fill", fill, 0);
    chk("t1_valid", vld, 0);
    chk("t1_cap", cap, 0);

    // 2: long strobe, one entry
    nf = 1'b0; cyc();
    nf = 1'b1; sin = 16'h1234; cyc();
    chk("t2_valid", vld, 1);
    chk("t2_out", sout, 16'h1234);
    chk("t2_cap", cap, 1);
    repeat (4) cyc();
    nf = 1'b0; cyc();
    chk("t2_fill", fill, 1);

    // 3: overfill
    do_flush();
    for (int i = 1; i <= 10; i++) frame(W'(i));
    chk("t3_fill", fill, 8);
    chk("t3_out", sout, 1);
    chk("t3_ovf", ovf, 1);
    chk("t3_dc", dc, 2);

    // 4: push while full with a simultaneous pop
    nf = 1'b1; sin = 16'h0099; rdy = 1'b1; cyc();
    nf = 1'b0; rdy = 1'b0;
    chk("t4_cap", cap, 1);
    chk("t4_fill", fill, 8);
    chk("t4_out", sout, 2);
    chk("t4_ovf", ovf, 1);
    chk("t4_dc", dc, 2);
    cyc();

    // 5: saturation and clear
    for (int i = 0; i < 300; i++) frame(W'(16'h4000 + i));
    chk("t5_dc_sat", dc, 255);
    chk("t5_ovf", ovf, 1);
    clr = 1'b1; cyc();
    clr = 1'b0;
    chk("t5_ovf_clr", ovf, 0);
    chk("t5_dc_clr", dc, 0);

    // 6: disabled capture, then flush with ready asserted
    do_flush();
    en = 1'b0;
    for (int i = 0; i < 5; i++) frame(W'(16'h7000 + i));
    chk("t6_fill_dis", fill, 0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) frame(W'(16'h7100 + i));
    chk("t6_fill4", fill, 4);
    flush = 1'b1; rdy = 1'b1; cyc();
    flush = 1'b0; rdy = 1'b0;
    chk("t6_fill_flush", fill, 0);
    chk("t6_valid_flush", vld, 0);

    // 7: random traffic in two ready-bias phases
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 800; i++) begin
        nf    = ($urandom % 3) == 0;
        sin   = W'($urandom);
        en    = ($urandom % 8) != 0;
        rdy   = (ph == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
        flush = ($urandom % 64) == 0;
        clr   = ($urandom % 50) == 0;
        cyc();
      end
    end
    nf = 1'b0; flush = 1'b0; clr = 1'b0; rdy = 1'b1;
    repeat (DEPTH + 4) cyc();
    chk("t7_drained", fill, 0);
    chk("t7_sb_empty", exp_q.size(), 0);
    rdy = 1'b0;

    // 8: asynchronous reset mid-operation
    en = 1'b1;
    for (int i = 0; i < 3; i++) frame(W'(16'hA000 + i));
    chk("t8_fill_pre", fill, 3);
    rst_n = 1'b0;
    #1;
    chk("t8_fill_rst", fill, 0);
    chk("t8_valid_rst", vld, 0);
    chk("t8_out_rst", sout, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    frame(16'h5A5A);
    chk("t8_fill_post", fill, 1);
    chk("t8_out_post", sout, 16'h5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
